monitoreo_scheduler: RTL and testbench

MONITOREO_SCHEDULER -- requirements
Module: monitoreo_scheduler

---
 rtl/monitoreo_pkg.sv | 22 ++
 rtl/monitoreo_rr_arb.sv | 52 +++++
 rtl/monitoreo_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_monitoreo_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monitoreo_pkg.sv
// ---------------------------------------------------------------------------
// monitoreo_pkg
// Shared definitions for the monitor time-sharing scheduler:
//   - default channel count, temperature width and dwell length
//   - TEMP_NOMINAL: temperature parked on the monitor while in reset (0.1 C)
//   - state_e: scheduler FSM states
// ---------------------------------------------------------------------------
package monitoreo_pkg;

    localparam int N_CH_DEF     = 4;
    localparam int TEMP_W_DEF   = 11;
    localparam int DWELL_DEF    = 8;
    localparam int TEMP_NOMINAL = 220;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DWELL,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/monitoreo_rr_arb.sv
// ---------------------------------------------------------------------------
// monitoreo_rr_arb
// Combinational round-robin arbiter. The search starts at channel `ptr` and
// wraps past N_CH-1 back to 0; the first requesting channel wins.
// Ports:
//   req   [N_CH-1:0]   per-channel request
//   ptr   [PTR_W-1:0]  highest-priority channel for this search
//   en                 arbitration allowed this cycle
//   gnt   [N_CH-1:0]   one-hot grant (all zero when !en or no request)
//   valid              a grant was issued
// ---------------------------------------------------------------------------
module monitoreo_rr_arb #(
    parameter int N_CH  = 4,
    parameter int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic             valid
);

    // Rotate requests right by ptr so that channel ptr sits at bit 0; a plain
    // fixed-priority pick on the rotated vector is then the round-robin pick.
    logic [2*N_CH-1:0] req_dbl;
    logic [2*N_CH-1:0] req_shr;
    logic [N_CH-1:0]   rot_req;
    logic [N_CH-1:0]   rot_pick;
    logic [2*N_CH-1:0] pick_shl;

    assign req_dbl = {req, req};
    assign req_shr = req_dbl >> ptr;
    assign rot_req = req_shr[N_CH-1:0];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign rot_pick[gi] = rot_req[gi];
            end else begin : g_rest
                assign rot_pick[gi] = rot_req[gi] & ~(|rot_req[gi-1:0]);
            end
        end
    endgenerate

    // Rotate the one-hot pick back left by ptr; the upper half holds the
    // bits that wrapped past N_CH-1.
    assign pick_shl = {{N_CH{1'b0}}, rot_pick} << ptr;

    assign gnt   = en ? (pick_shl[N_CH-1:0] | pick_shl[2*N_CH-1:N_CH]) : '0;
    assign valid = en & (|req);

endmodule

// File: rtl/monitoreo_scheduler.sv
// ---------------------------------------------------------------------------
// monitoreo_scheduler
// Time-shares one temperature monitor between N_CH sensor channels. A granted
// channel's temperature is latched onto mon_temp, the monitor is cleared for
// one cycle, allowed to settle for DWELL cycles, and its results are then
// captured into that channel's status registers and the channel is acked.
// Heat/fan demands of all channels are merged into one actuator command pair;
// fan wins when both are demanded and conflicto flags it.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid  [N_CH]                per-channel request (held until ack)
//   req_temp   [N_CH*TEMP_W]         per-channel signed temperature
//   req_ack    [N_CH]                one-hot completion pulse
//   mon_temp   [TEMP_W]              temperature presented to the monitor
//   mon_clr                          monitor clear pulse
//   mon_estado/alerta/calefactor/ventilador   monitor results
//   ch_estado  [N_CH*2], ch_alerta [N_CH]      last captured per-channel state
//   calefactor, ventilador, conflicto          aggregated actuator commands
//   busy, cur_ch                     service in progress / channel in service
// ---------------------------------------------------------------------------
module monitoreo_scheduler
    import monitoreo_pkg::*;
#(
    parameter int  N_CH   = N_CH_DEF,
    parameter int  TEMP_W = TEMP_W_DEF,
    parameter int  DWELL  = DWELL_DEF,
    localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*TEMP_W-1:0]   req_temp,
    output logic [N_CH-1:0]          req_ack,
    output logic [TEMP_W-1:0]        mon_temp,
    output logic                     mon_clr,
    input  logic [1:0]               mon_estado,
    input  logic                     mon_alerta,
    input  logic                     mon_calefactor,
    input  logic                     mon_ventilador,
    output logic [N_CH*2-1:0]        ch_estado,
    output logic [N_CH-1:0]          ch_alerta,
    output logic                     calefactor,
    output logic                     ventilador,
    output logic                     conflicto,
    output logic                     busy,
    output logic [PTR_W-1:0]         cur_ch
);

    state_e               state_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     cur_ch_q;
    logic [7:0]           dwell_cnt_q;
    logic [TEMP_W-1:0]    mon_temp_q;
    logic                 mon_clr_q;
    logic                 busy_q;
    logic [N_CH-1:0]      req_ack_q;
    logic                 calef_q;
    logic                 vent_q;
    logic                 confl_q;

    logic [2*N_CH-1:0]    estado_q, estado_d;
    logic [N_CH-1:0]      alerta_q, alerta_d;
    logic [N_CH-1:0]      heat_q, heat_d;
    logic [N_CH-1:0]      fan_q, fan_d;

    logic [N_CH-1:0]      arb_gnt;
    logic                 arb_valid;
    logic [PTR_W-1:0]     gnt_idx;
    logic [TEMP_W-1:0]    gnt_temp;
    logic [PTR_W-1:0]     ptr_next;
    logic [N_CH-1:0]      cur_onehot;
    logic [N_CH-1:0]      cap_hit;
    logic                 heat_any;
    logic                 fan_any;

    monitoreo_rr_arb #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (state_q == ST_IDLE),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // Encode the grant and pick the granted channel's temperature.
    always_comb begin
        gnt_idx  = '0;
        gnt_temp = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                gnt_temp = req_temp[i*TEMP_W +: TEMP_W];
            end
        end
    end

    // Next search starts just past the granted channel, wrapping to 0.
    assign ptr_next = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // Per-channel status capture: only the channel in service is overwritten,
    // and only during CAPTURE.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign cur_onehot[gi] = (cur_ch_q == PTR_W'(gi));
            assign cap_hit[gi]    = (state_q == ST_CAPTURE) && cur_onehot[gi];

            assign estado_d[gi*2 +: 2] = cap_hit[gi] ? mon_estado     : estado_q[gi*2 +: 2];
            assign alerta_d[gi]        = cap_hit[gi] ? mon_alerta     : alerta_q[gi];
            assign heat_d[gi]          = cap_hit[gi] ? mon_calefactor : heat_q[gi];
            assign fan_d[gi]           = cap_hit[gi] ? mon_ventilador : fan_q[gi];
        end
    endgenerate

    // Aggregates are taken from the next-state flags so the registered
    // outputs change in the cycle right after CAPTURE.
    assign heat_any = |heat_d;
    assign fan_any  = |fan_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cur_ch_q    <= '0;
            dwell_cnt_q <= '0;
            mon_temp_q  <= TEMP_W'(TEMP_NOMINAL);
            mon_clr_q   <= 1'b1;
            busy_q      <= 1'b0;
            req_ack_q   <= '0;
            estado_q    <= '0;
            alerta_q    <= '0;
            heat_q      <= '0;
            fan_q       <= '0;
            calef_q     <= 1'b0;
            vent_q      <= 1'b0;
            confl_q     <= 1'b0;
        end else begin
            mon_clr_q <= 1'b0;
            req_ack_q <= '0;

            estado_q  <= estado_d;
            alerta_q  <= alerta_d;
            heat_q    <= heat_d;
            fan_q     <= fan_d;
            calef_q   <= heat_any & ~fan_any;
            vent_q    <= fan_any;
            confl_q   <= heat_any & fan_any;

            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_q    <= ST_CLEAR;
                        cur_ch_q   <= gnt_idx;
                        mon_temp_q <= gnt_temp;
                        rr_ptr_q   <= ptr_next;
                        mon_clr_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q     <= ST_DWELL;
                    dwell_cnt_q <= '0;
                end
                ST_DWELL: begin
                    if (dwell_cnt_q == 8'(DWELL - 1)) begin
                        state_q   <= ST_CAPTURE;
                        req_ack_q <= cur_onehot;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ack    = req_ack_q;
    assign mon_temp   = mon_temp_q;
    assign mon_clr    = mon_clr_q;
    assign ch_estado  = estado_q;
    assign ch_alerta  = alerta_q;
    assign calefactor = calef_q;
    assign ventilador = vent_q;
    assign conflicto  = confl_q;
    assign busy       = busy_q;
    assign cur_ch     = cur_ch_q;

endmodule

// File: tb/tb_monitoreo_scheduler.sv
// ---------------------------------------------------------------------------
// tb_monitoreo_scheduler
// Directed stimulus with a scoreboard: each expected ack (channel, latched
// temperature, cycle) is queued when the request is issued; a monitor process
// pops and checks it when req_ack fires, then checks the captured status and
// aggregated actuator outputs one cycle later. The monitor inputs are driven
// by a simple stand-in that classifies mon_temp.
// ---------------------------------------------------------------------------
module tb_monitoreo_scheduler;

    localparam int N_CH   = 4;
    localparam int TEMP_W = 11;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH*TEMP_W-1:0] req_temp;
    logic [N_CH-1:0]        req_ack;
    logic [TEMP_W-1:0]      mon_temp;
    logic                   mon_clr;
    logic [1:0]             mon_estado;
    logic                   mon_alerta;
    logic                   mon_calefactor;
    logic                   mon_ventilador;
    logic [N_CH*2-1:0]      ch_estado;
    logic [N_CH-1:0]        ch_alerta;
    logic                   calefactor;
    logic                   ventilador;
    logic                   conflicto;
    logic                   busy;
    logic [1:0]             cur_ch;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int ch;
        int temp;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    monitoreo_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_temp       (req_temp),
        .req_ack        (req_ack),
        .mon_temp       (mon_temp),
        .mon_clr        (mon_clr),
        .mon_estado     (mon_estado),
        .mon_alerta     (mon_alerta),
        .mon_calefactor (mon_calefactor),
        .mon_ventilador (mon_ventilador),
        .ch_estado      (ch_estado),
        .ch_alerta      (ch_alerta),
        .calefactor     (calefactor),
        .ventilador     (ventilador),
        .conflicto      (conflicto),
        .busy           (busy),
        .cur_ch         (cur_ch)
    );

    // Stand-in monitor: heat below 18.0 C, fan above 26.0 C, alert above 30.0 C.
    function automatic logic f_heat(input int t);
        return t < 180;
    endfunction
    function automatic logic f_fan(input int t);
        return t > 260;
    endfunction
    function automatic logic f_alerta(input int t);
        return t > 300;
    endfunction
    function automatic logic [1:0] f_est(input int t);
        if (f_heat(t)) return 2'd1;
        if (f_fan(t))  return 2'd2;
        return 2'd0;
    endfunction

    assign mon_calefactor = f_heat(int'($signed(mon_temp)));
    assign mon_ventilador = f_fan(int'($signed(mon_temp)));
    assign mon_alerta     = f_alerta(int'($signed(mon_temp)));
    assign mon_estado     = f_est(int'($signed(mon_temp)));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_temp(input int ch, input int t);
        req_temp[ch*TEMP_W +: TEMP_W] = TEMP_W'(t);
    endtask

    task automatic push(input int ch, input int t, input int cy);
        exp_t e;
        e.ch   = ch;
        e.temp = t;
        e.cyc  = cy;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mon_clr"},  32'(mon_clr),    32'd1);
        check({tag, "_mon_temp"}, 32'(mon_temp),   32'd220);
        check({tag, "_req_ack"},  32'(req_ack),    32'd0);
        check({tag, "_estado"},   32'(ch_estado),  32'd0);
        check({tag, "_alerta"},   32'(ch_alerta),  32'd0);
        check({tag, "_calef"},    32'(calefactor), 32'd0);
        check({tag, "_vent"},     32'(ventilador), 32'd0);
        check({tag, "_confl"},    32'(conflicto),  32'd0);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_cur_ch"},   32'(cur_ch),     32'd0);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t       e;
        logic [3:0] m_heat  = '0;
        logic [3:0] m_fan   = '0;
        logic [3:0] m_alert = '0;
        logic [7:0] m_est   = '0;
        logic       post    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_heat  = '0;
                m_fan   = '0;
                m_alert = '0;
                m_est   = '0;
                post    = 1'b0;
            end else begin
                if (post) begin
                    post = 1'b0;
                    check("cap_estado", 32'(ch_estado),  32'(m_est));
                    check("cap_alerta", 32'(ch_alerta),  32'(m_alert));
                    check("agg_calef",  32'(calefactor), 32'((|m_heat) & ~(|m_fan)));
                    check("agg_vent",   32'(ventilador), 32'(|m_fan));
                    check("agg_confl",  32'(conflicto),  32'((|m_heat) & (|m_fan)));
                end
                if (req_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_ack: got 0x%0h expected none (cycle %0d)", req_ack, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        $display("ack ch%0d temp=%0d cycle=%0d", e.ch, e.temp, cyc);
                        check("ack_onehot", 32'(req_ack),  32'(1) << e.ch);
                        check("ack_cycle",  32'(cyc),      32'(e.cyc));
                        check("ack_temp",   32'(mon_temp), 32'(e.temp));
                        m_heat[e.ch]        = f_heat(e.temp);
                        m_fan[e.ch]         = f_fan(e.temp);
                        m_alert[e.ch]       = f_alerta(e.temp);
                        m_est[e.ch*2 +: 2]  = f_est(e.temp);
                        post = 1'b1;
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int c;
        rst       = 1'b1;
        req_valid = '0;
        req_temp  = '0;
        for (int k = 0; k < N_CH; k++) set_temp(k, 220);
        tick(2);
        check_reset("rst_init");
        rst = 1'b0;
        tick(1);

        // Single request on channel 0, monitor reports heat.
        set_temp(0, 150);
        c = cyc;
        req_valid = 4'b0001;
        push(0, 150, c + 10);
        tick(1);
        check("a_clear_pulse", 32'(mon_clr),  32'd1);
        check("a_busy",        32'(busy),     32'd1);
        check("a_cur_ch",      32'(cur_ch),   32'd0);
        check("a_mon_temp",    32'(mon_temp), 32'd150);
        tick(1);
        check("a_clear_len",   32'(mon_clr),  32'd0);
        tick(8);
        req_valid = '0;
        tick(3);

        // req_temp changed mid-dwell: latched value must stay.
        c = cyc;
        req_valid = 4'b0001;
        push(0, 150, c + 10);
        tick(4);
        set_temp(0, 350);
        tick(1);
        check("b_temp_dwell", 32'(mon_temp), 32'd150);
        tick(5);
        req_valid = '0;
        tick(4);
        check("b_temp_idle",  32'(mon_temp), 32'd150);
        check("b_busy_idle",  32'(busy),     32'd0);

        // Reset while idle clears captured status.
        rst = 1'b1;
        tick(1);
        check_reset("rst_idle");
        rst = 1'b0;
        tick(1);

        // All four requesting continuously.
        set_temp(0, 150);
        set_temp(1, 220);
        set_temp(2, 270);
        set_temp(3, 350);
        c = cyc;
        req_valid = 4'b1111;
        push(0, 150, c + 10);
        push(1, 220, c + 21);
        push(2, 270, c + 32);
        push(3, 350, c + 43);
        push(0, 150, c + 54);
        tick(54);
        req_valid = '0;
        tick(3);

        // Reset during channel 2 dwell: no ack, next grant goes to channel 0.
        c = cyc;
        req_valid = 4'b0100;
        tick(1);
        check("e_grant_ch2", 32'(cur_ch), 32'd2);
        tick(4);
        rst       = 1'b1;
        req_valid = '0;
        tick(1);
        check_reset("rst_dwell");
        rst = 1'b0;
        tick(12);

        // Channels 0,1,2: channel 1 heat, channel 2 fan -> conflict.
        set_temp(0, 220);
        set_temp(1, 100);
        set_temp(2, 270);
        c = cyc;
        req_valid = 4'b0111;
        push(0, 220, c + 10);
        push(1, 100, c + 21);
        push(2, 270, c + 32);
        tick(1);
        check("d_grant_after_rst", 32'(cur_ch), 32'd0);
        tick(9);
        req_valid = 4'b0110;
        tick(11);
        req_valid = 4'b0100;
        tick(11);
        req_valid = '0;
        tick(3);

        // Service channel 3, then 1001 must wrap to channel 0 first.
        set_temp(3, 220);
        c = cyc;
        req_valid = 4'b1000;
        push(3, 220, c + 10);
        tick(10);
        req_valid = '0;
        tick(2);
        c = cyc;
        req_valid = 4'b1001;
        push(0, 220, c + 10);
        push(3, 220, c + 21);
        tick(1);
        check("f_ptr_wrap", 32'(cur_ch), 32'd0);
        tick(9);
        req_valid = 4'b1000;
        tick(11);
        req_valid = '0;
        tick(3);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
